// File: rtl/clint_ctrl_pkg.sv
// Shared constants and types for the core-local trap sequencer (clint_ctrl).
package clint_ctrl_pkg;

  localparam int unsigned CSR_AW  = 12;
  localparam int unsigned CAUSE_W = 32;

  // CSR addresses
  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_AW-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  // mcause values
  localparam logic [CAUSE_W-1:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMER = 32'h8000_0007;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL = 32'h0000_000B;

  // mstatus / mie bit positions
  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;
  localparam int unsigned MEIE_BIT = 11;
  localparam int unsigned MTIE_BIT = 7;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_MEPC   = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_STATUS = 3'd3,
    ST_TRAP        = 3'd4,
    ST_MRET_STATUS = 3'd5,
    ST_MRET_JUMP   = 3'd6
  } state_e;

  // Decision produced by the request arbiter in IDLE
  typedef struct packed {
    logic               accept;
    logic               is_mret;
    logic               use_jump;
    logic [CAUSE_W-1:0] cause;
  } trap_req_t;

endpackage

// File: rtl/clint_ctrl_cause_sel.sv
// Request arbiter: picks mret > ecall > ext > timer and reports cause and mepc source.
module clint_ctrl_cause_sel
  import clint_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  mret_i,
  input  logic                  ecall_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  jump_enable_i,
  input  logic                  stall_busy_i,
  input  logic [DATA_WIDTH-1:0] mstatus_i,
  input  logic [DATA_WIDTH-1:0] mie_i,
  output trap_req_t             req_c
);

  logic glb_en;
  logic ext_ok;
  logic tmr_ok;
  logic unused_bits;

  assign glb_en = mstatus_i[MIE_BIT];
  // Async interrupts need global + local enable and an unstalled pipeline
  assign ext_ok = irq_ext_i   & glb_en & mie_i[MEIE_BIT] & ~stall_busy_i;
  assign tmr_ok = irq_timer_i & glb_en & mie_i[MTIE_BIT] & ~stall_busy_i;

  assign unused_bits = ^{mstatus_i[DATA_WIDTH-1:MIE_BIT+1], mstatus_i[MIE_BIT-1:0],
                         mie_i[DATA_WIDTH-1:MEIE_BIT+1], mie_i[MEIE_BIT-1:MTIE_BIT+1],
                         mie_i[MTIE_BIT-1:0]};

  // Fixed-priority selection
  always_comb begin
    req_c = '0;
    if (mret_i) begin
      req_c.accept  = 1'b1;
      req_c.is_mret = 1'b1;
    end else if (ecall_i) begin
      req_c.accept = 1'b1;
      req_c.cause  = CAUSE_ECALL;
    end else if (ext_ok) begin
      req_c.accept   = 1'b1;
      req_c.cause    = CAUSE_EXT;
      req_c.use_jump = jump_enable_i;
    end else if (tmr_ok) begin
      req_c.accept   = 1'b1;
      req_c.cause    = CAUSE_TIMER;
      req_c.use_jump = jump_enable_i;
    end
  end

endmodule

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: saves mepc/mcause/mstatus, then redirects to the trap
// vector; mret restores mstatus and redirects to mepc.
// Optional feature macro: CLINT_VECTORED_EN (vectored mtvec mode for async causes).
module clint_ctrl
  import clint_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  irq_ext_i,
  input  logic                  irq_timer_i,
  input  logic                  ecall_i,
  input  logic                  mret_i,
  input  logic [ADDR_WIDTH-1:0] id_pc_i,
  input  logic                  jump_enable_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  stall_busy_i,
  input  logic [DATA_WIDTH-1:0] csr_mstatus_i,
  input  logic [DATA_WIDTH-1:0] csr_mie_i,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  csr_we_o,
  output logic [CSR_AW-1:0]     csr_waddr_o,
  output logic [DATA_WIDTH-1:0] csr_wdata_o,
  output logic                  hold_o,
  output logic                  interrupt_enable_o,
  output logic [ADDR_WIDTH-1:0] int_addr_o
);

  state_e                 state_q;
  state_e                 state_d;
  trap_req_t              req_c;
  logic [DATA_WIDTH-1:0]  cause_q;
  logic [ADDR_WIDTH-1:0]  target_q;
  logic [ADDR_WIDTH-1:0]  mepc_sel_c;
  logic [ADDR_WIDTH-1:0]  base_c;
  logic [ADDR_WIDTH-1:0]  target_c;
  logic                   trap_accept_c;

  logic                   csr_we_d;
  logic [CSR_AW-1:0]      csr_waddr_d;
  logic [DATA_WIDTH-1:0]  csr_wdata_d;
  logic                   int_en_d;
  logic [ADDR_WIDTH-1:0]  int_addr_d;

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0
  function automatic logic [DATA_WIDTH-1:0] status_on_trap(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r           = s;
    r[MPIE_BIT] = s[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  // mstatus on mret: MIE <- MPIE, MPIE <- 1
  function automatic logic [DATA_WIDTH-1:0] status_on_mret(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r           = s;
    r[MIE_BIT]  = s[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

  clint_ctrl_cause_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cause_sel (
    .mret_i        (mret_i),
    .ecall_i       (ecall_i),
    .irq_ext_i     (irq_ext_i),
    .irq_timer_i   (irq_timer_i),
    .jump_enable_i (jump_enable_i),
    .stall_busy_i  (stall_busy_i),
    .mstatus_i     (csr_mstatus_i),
    .mie_i         (csr_mie_i),
    .req_c         (req_c)
  );

  assign mepc_sel_c    = req_c.use_jump ? jump_addr_i : id_pc_i;
  assign base_c        = {csr_mtvec_i[ADDR_WIDTH-1:2], 2'b00};
  assign trap_accept_c = (state_q == ST_IDLE) && req_c.accept && !req_c.is_mret;

`ifdef CLINT_VECTORED_EN
  // Vectored mode only offsets asynchronous causes
  always_comb begin
    target_c = base_c;
    if ((csr_mtvec_i[1:0] == 2'b01) && req_c.cause[CAUSE_W-1]) begin
      target_c = base_c + ADDR_WIDTH'({req_c.cause[3:0], 2'b00});
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^csr_mtvec_i[1:0];
  assign target_c    = base_c;
`endif

  // Stall the pipeline from the accept cycle until the redirect beat
  assign hold_o = (state_q == ST_IDLE) ? req_c.accept
                                       : ((state_q != ST_TRAP) && (state_q != ST_MRET_JUMP));

  // State, trap latches and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q            <= ST_IDLE;
      cause_q            <= '0;
      target_q           <= '0;
      csr_we_o           <= 1'b0;
      csr_waddr_o        <= '0;
      csr_wdata_o        <= '0;
      interrupt_enable_o <= 1'b0;
      int_addr_o         <= '0;
    end else begin
      state_q            <= state_d;
      csr_we_o           <= csr_we_d;
      csr_waddr_o        <= csr_waddr_d;
      csr_wdata_o        <= csr_wdata_d;
      interrupt_enable_o <= int_en_d;
      int_addr_o         <= int_addr_d;
      if (trap_accept_c) begin
        cause_q  <= DATA_WIDTH'(req_c.cause);
        target_q <= target_c;
      end
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_d     = state_q;
    csr_we_d    = 1'b0;
    csr_waddr_d = '0;
    csr_wdata_d = '0;
    int_en_d    = 1'b0;
    int_addr_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_c.accept) begin
          csr_we_d = 1'b1;
          if (req_c.is_mret) begin
            state_d     = ST_MRET_STATUS;
            csr_waddr_d = CSR_MSTATUS;
            csr_wdata_d = status_on_mret(csr_mstatus_i);
          end else begin
            state_d     = ST_SAVE_MEPC;
            csr_waddr_d = CSR_MEPC;
            csr_wdata_d = DATA_WIDTH'(mepc_sel_c);
          end
        end
      end
      ST_SAVE_MEPC: begin
        state_d     = ST_SAVE_CAUSE;
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MCAUSE;
        csr_wdata_d = cause_q;
      end
      ST_SAVE_CAUSE: begin
        state_d     = ST_SAVE_STATUS;
        csr_we_d    = 1'b1;
        csr_waddr_d = CSR_MSTATUS;
        csr_wdata_d = status_on_trap(csr_mstatus_i);
      end
      ST_SAVE_STATUS: begin
        state_d    = ST_TRAP;
        int_en_d   = 1'b1;
        int_addr_d = target_q;
      end
      ST_TRAP: begin
        state_d = ST_IDLE;
      end
      ST_MRET_STATUS: begin
        state_d    = ST_MRET_JUMP;
        int_en_d   = 1'b1;
        int_addr_d = csr_mepc_i[ADDR_WIDTH-1:0];
      end
      ST_MRET_JUMP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
